theta_page_sequencer: RTL and testbench
=======================================

# theta_page_sequencer

Initiator-side sequencer for the column-parity (theta) unit. It walks a 64-page Keccak state stored in an external single-port page memory, slice by slice (z = 0..63). For each slice it presents the current page and the previous page (z-1, wrapping to 63) to the parity unit, then runs the `cal_start`/`cal_finish` handshake. It writes the returned `parity_out` back in place. It sits between the state memory and the parity unit and is started by the round controller.

## Interface
- `NUM_PAGES`, 64: pages per state; the last page index is `NUM_PAGES-1`.
- `ADDR_W`, 6: page address width; must satisfy 2^`ADDR_W` >= `NUM_PAGES`.
- `PAGE_W`, 25: bits per page (5x5 slice), indexed [0:24].
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request to process the whole state.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done`, output, 1: one-cycle pulse after the last write-back.
- `mem_addr`, output, `ADDR_W`: page address.
- `mem_rd`, output, 1: read strobe; data is valid on `mem_rdata` one cycle later.
- `mem_rdata`, input, [0:24]: read data.
- `mem_wr`, output, 1: write strobe; memory writes `mem_wdata` at `mem_addr` on the same edge.
- `mem_wdata`, output, [0:24]: write data.
- `cal_start`, output, 1: one-cycle request to the parity unit.
- `cal_finish`, input, 1: parity unit completion; `parity_out` is valid in any cycle `cal_finish` is high.
- `cur_page`, output, [0:24]: registered current page to the parity unit.
- `prev_page`, output, [0:24]: registered previous page to the parity unit.
- `parity_out`, input, [0:24]: result from the parity unit.

## Operation
- Registers: `z` (`ADDR_W` bits), `cur_r`, `prev_r`, `res_r` (each [0:24]).
- The FSM has nine states: IDLE, RD_LAST, LD_LAST, RD_CUR, LD_CUR, CAL, WAIT, WR, DONE.
- IDLE: if `start`=1, clear `z` and go to RD_LAST. In every other state `start` is ignored.
- RD_LAST: `mem_rd`=1, `mem_addr`=`NUM_PAGES-1`. Go to LD_LAST.
- LD_LAST: `prev_r` <= `mem_rdata`. Go to RD_CUR. This captures the original page 63 before it is overwritten.
- RD_CUR: `mem_rd`=1, `mem_addr`=`z`. Go to LD_CUR.
- LD_CUR: `cur_r` <= `mem_rdata`. Go to CAL.
- CAL: `cal_start`=1 for exactly one cycle. Go to WAIT.
- WAIT: hold `cur_page`/`prev_page` stable. When `cal_finish`=1, `res_r` <= `parity_out` and go to WR.
  - `cal_finish` is not sampled in CAL, so a finish level left over from the previous page is never mistaken for a new result.
- WR: `mem_wr`=1, `mem_addr`=`z`, `mem_wdata`=`res_r`. `prev_r` <= `cur_r` (the original, unmodified page z).
  - If `z`=`NUM_PAGES-1`, go to DONE.
  - Otherwise `z` <= `z`+1 and go to RD_CUR.
- DONE: `done`=1, then go to IDLE.
- `cur_page`=`cur_r` and `prev_page`=`prev_r` at all times.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- Write-back is in place. Because `prev_r` always holds original data, in-place writes never corrupt later slices.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE; `z`, `cur_r`, `prev_r`, `res_r` = 0; `busy`, `done`, `mem_rd`, `mem_wr`, `cal_start` = 0; `mem_addr` and `mem_wdata` = 0.
- Reset mid-run aborts immediately. No further reads or writes occur; memory keeps whatever was already written.
- `start` is sampled in cycle 0. RD_LAST is cycle 1, LD_LAST cycle 2, and the first RD_CUR cycle 3.
- Let L (>= 1) be the number of cycles from the `cal_start` edge to the first cycle `cal_finish` is sampled high. Each page then takes 4+L cycles: RD_CUR, LD_CUR, CAL, L WAIT cycles, WR.
- `done` is asserted in cycle 3 + `NUM_PAGES`·(4+L). With L=1 this is cycle 323.
- `busy` = (state != IDLE), combinational from state.
- `cal_finish` held high indefinitely: exactly one capture per page. It is ignored outside WAIT.
- `cal_finish` never arrives: the FSM stalls in WAIT with `busy`=1. There is no timeout.

## Test plan
- Page z = 25'h0000001 << (z mod 25); parity model with fixed L=1 -> 64 writes in ascending z; the page 0 request has `prev_page` = original page 63; `done` in cycle 323.
- Variable L (random 1..5 per page) -> identical memory contents; every `cal_start` is exactly one cycle and never reissued before the matching capture.
- `cal_finish` tied high from cycle 0 -> capture happens only in WAIT; each `parity_out` is captured exactly once; writes remain correct.
- `start` pulsed again while `busy` -> ignored; exactly 64 writes and one `done`.
- `rst`=0 asserted in WAIT of z=10 -> outputs are zero immediately; no write to page 10; a later `start` completes a full correct pass.
- All-zero state -> 64 writes of 25'h0; the final write targets address 63 before `done`.

Source files
------------

// File: rtl/theta_page_sequencer.sv
// Walks a 64-page Keccak state slice by slice, feeding current/previous page to the
// column-parity unit and writing each result back in place.
module theta_page_sequencer #(
    parameter int NUM_PAGES = 64,
    parameter int ADDR_W    = 6,
    parameter int PAGE_W    = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [0:PAGE_W-1] mem_rdata,
    output logic              mem_wr,
    output logic [0:PAGE_W-1] mem_wdata,
    output logic              cal_start,
    input  logic              cal_finish,
    output logic [0:PAGE_W-1] cur_page,
    output logic [0:PAGE_W-1] prev_page,
    input  logic [0:PAGE_W-1] parity_out
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_LAST = 4'd1;
    localparam logic [3:0] S_LD_LAST = 4'd2;
    localparam logic [3:0] S_RD_CUR  = 4'd3;
    localparam logic [3:0] S_LD_CUR  = 4'd4;
    localparam logic [3:0] S_CAL     = 4'd5;
    localparam logic [3:0] S_WAIT    = 4'd6;
    localparam logic [3:0] S_WR      = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(NUM_PAGES - 1);

    logic [3:0]        state;
    logic [ADDR_W-1:0] z;
    logic [0:PAGE_W-1] cur_r;
    logic [0:PAGE_W-1] prev_r;
    logic [0:PAGE_W-1] res_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            z      <= '0;
            cur_r  <= '0;
            prev_r <= '0;
            res_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        z     <= '0;
                        state <= S_RD_LAST;
                    end
                end
                S_RD_LAST: state <= S_LD_LAST;
                S_LD_LAST: begin
                    prev_r <= mem_rdata;
                    state  <= S_RD_CUR;
                end
                S_RD_CUR: state <= S_LD_CUR;
                S_LD_CUR: begin
                    cur_r <= mem_rdata;
                    state <= S_CAL;
                end
                S_CAL: state <= S_WAIT;
                // finish is only honoured here, so a level held over from the last page is never reused
                S_WAIT: begin
                    if (cal_finish) begin
                        res_r <= parity_out;
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    prev_r <= cur_r;
                    if (z == LAST_PAGE) begin
                        state <= S_DONE;
                    end else begin
                        z     <= z + ADDR_W'(1);
                        state <= S_RD_CUR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        cal_start = 1'b0;
        case (state)
            S_RD_LAST: begin
                mem_rd   = 1'b1;
                mem_addr = LAST_PAGE;
            end
            S_RD_CUR: begin
                mem_rd   = 1'b1;
                mem_addr = z;
            end
            S_CAL: cal_start = 1'b1;
            S_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = z;
                mem_wdata = res_r;
            end
            default: ;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign cur_page  = cur_r;
    assign prev_page = prev_r;

endmodule

// File: tb/tb_theta_page_sequencer.sv
// Scoreboard bench for theta_page_sequencer: behavioural page memory and parity unit
// with configurable latency; expected writes/requests queued at start, popped on output.
module tb_theta_page_sequencer;

    typedef struct packed {
        logic [5:0]  addr;
        logic [0:24] data;
    } wr_t;

    typedef struct packed {
        logic [0:24] cur;
        logic [0:24] prev;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  mem_addr;
    logic        mem_rd;
    logic [0:24] mem_rdata;
    logic        mem_wr;
    logic [0:24] mem_wdata;
    logic        cal_start;
    logic        cal_finish;
    logic [0:24] cur_page;
    logic [0:24] prev_page;
    logic [0:24] parity_out;

    theta_page_sequencer #(
        .NUM_PAGES(64),
        .ADDR_W   (6),
        .PAGE_W   (25)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .cal_start (cal_start),
        .cal_finish(cal_finish),
        .cur_page  (cur_page),
        .prev_page (prev_page),
        .parity_out(parity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Page memory model: registered read, write on the strobe edge
    logic [0:24] mem      [64];
    logic [0:24] init_img [64];
    logic [0:24] exp_img  [64];
    logic        load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_img[i];
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    function automatic logic [0:24] pf(input logic [0:24] c, input logic [0:24] p);
        return c ^ {p[1:24], p[0]};
    endfunction

    // Parity unit model: result latched on cal_start, finish after L edges
    logic        tie_high;
    logic        rand_l;
    int          lfix;
    int          cnt;
    logic [0:24] pres;

    always @(posedge clk) begin
        if (cal_start) begin
            pres <= pf(cur_page, prev_page);
            cnt  <= rand_l ? int'($urandom_range(1, 5)) : lfix;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign cal_finish = tie_high || (cnt == 1);
    assign parity_out = pres;

    wr_t  wq[$];
    req_t rq[$];
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   req_cnt = 0;
    logic outstanding = 1'b0;
    logic [5:0] last_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        req_t r;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (!rst_n) outstanding = 1'b0;
            if (cal_start) begin
                chk("cal_reissue", 64'(outstanding), 64'd0);
                chk("req_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("req_cur", 64'(cur_page), 64'(r.cur));
                    chk("req_prev", 64'(prev_page), 64'(r.prev));
                end
                outstanding = 1'b1;
                req_cnt++;
            end
            if (mem_wr) begin
                chk("rd_wr_excl", 64'(mem_rd), 64'd0);
                chk("wr_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(w.addr));
                    chk("wr_data", 64'(mem_wdata), 64'(w.data));
                end
                last_addr   = mem_addr;
                outstanding = 1'b0;
                wr_cnt++;
            end
            if (done) done_cnt++;
        end
    endtask

    task automatic push_pass();
        for (int z = 0; z < 64; z++) begin
            logic [0:24] c;
            logic [0:24] p;
            c = mem[z];
            p = mem[(z + 63) % 64];
            exp_img[z] = pf(c, p);
            wq.push_back('{addr: 6'(z), data: pf(c, p)});
            rq.push_back('{cur: c, prev: p});
        end
    endtask

    task automatic load_image(input bit zero);
        for (int z = 0; z < 64; z++) init_img[z] = zero ? 25'h0 : (25'h1 << (z % 25));
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic do_run(input int exp_cyc, input bit mid_start);
        int w0;
        int d0;
        int cyc;
        int bad;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_pass();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1 cyc++;
            start = (mid_start && cyc == 50);
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd1);
        if (exp_cyc > 0) chk("done_cycle", 64'(cyc), 64'(exp_cyc));
        chk("last_wr_addr", 64'(last_addr), 64'd63);
        @(posedge clk);
        #1 chk("busy_after_done", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        chk("write_count", 64'(wr_cnt - w0), 64'd64);
        chk("wr_queue_empty", 64'(wq.size()), 64'd0);
        bad = 0;
        for (int z = 0; z < 64; z++) if (mem[z] !== exp_img[z]) bad++;
        chk("mem_image", 64'(bad), 64'd0);
    endtask

    initial begin
        int r0;
        int cyc;
        fork
            monitor();
        join_none
        rst_n    = 1'b0;
        start    = 1'b0;
        load     = 1'b0;
        tie_high = 1'b0;
        rand_l   = 1'b0;
        lfix     = 1;
        load_image(1'b0);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_cal_start", 64'(cal_start), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cur_page", 64'(cur_page), 64'd0);
        chk("rst_prev_page", 64'(prev_page), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Fixed latency 1
        do_run(323, 1'b0);

        // Random latency 1..5
        load_image(1'b0);
        rand_l = 1'b1;
        do_run(0, 1'b0);
        rand_l = 1'b0;

        // cal_finish held high throughout
        load_image(1'b0);
        tie_high = 1'b1;
        do_run(323, 1'b0);
        tie_high = 1'b0;

        // Second start while busy
        load_image(1'b0);
        do_run(323, 1'b1);

        // Reset in WAIT of page 10
        load_image(1'b0);
        lfix = 5;
        r0 = req_cnt;
        push_pass();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (req_cnt < r0 + 11 && cyc < 3000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("reach_page10", 64'(req_cnt - r0), 64'd11);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_mem_wr", 64'(mem_wr), 64'd0);
        chk("abort_mem_rd", 64'(mem_rd), 64'd0);
        chk("abort_cal_start", 64'(cal_start), 64'd0);
        chk("abort_cur_page", 64'(cur_page), 64'd0);
        chk("abort_prev_page", 64'(prev_page), 64'd0);
        chk("abort_mem_addr", 64'(mem_addr), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_pending_writes", 64'(wq.size()), 64'd54);
        chk("abort_page10_intact", 64'(mem[10]), 64'(init_img[10]));
        chk("abort_page9_written", 64'(mem[9]), 64'(exp_img[9]));
        wq.delete();
        rq.delete();
        @(negedge clk) rst_n = 1'b1;
        do_run(3 + 64 * 9, 1'b0);

        // All-zero state
        load_image(1'b1);
        lfix = 1;
        do_run(323, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
